// File: rtl/divider_pkg.sv
// Shared constants for the restoring divider: default quotient width, counter
// width and the sequencing FSM state encoding.
package divider_pkg;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_ITER  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/div_iter_counter.sv
// Iteration counter for the divider sequencer: counts ITER cycles and flags the
// final quotient bit, wrapping to zero after it.
module div_iter_counter
    import divider_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic          last
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign last  = (count_q == CW'(WIDTH - 1));
    assign count = count_q;

    // Explicit wrap keeps non-power-of-two widths on the 0..WIDTH-1 range.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = last ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/divider_control.sv
// Sequencing FSM for the restoring divider: LOAD, zero-divisor CHECK, one ITER
// cycle per quotient bit, then a single-cycle DONE pulse.
module divider_control
    import divider_pkg::*;
#(
    parameter int WIDTH = divider_pkg::WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     divisor_zero,
    input  logic                     sub_negative,
    output logic                     load_divisor,
    output logic                     load_dividend,
    output logic                     step,
    output logic                     write_rem,
    output logic                     busy,
    output logic                     done,
    output logic                     div_by_zero,
    output logic [$clog2(WIDTH)-1:0] iter_count
);

    localparam int CW = $clog2(WIDTH);

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic       div_by_zero_q;
    logic       div_by_zero_d;
    logic       cnt_last;

    div_iter_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q == ST_LOAD),
        .enable (state_q == ST_ITER),
        .count  (iter_count),
        .last   (cnt_last)
    );

    // The error flag is cleared on leaving LOAD so it survives from DONE
    // until the next operation is accepted.
    always_comb begin
        state_d       = state_q;
        div_by_zero_d = div_by_zero_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d       = ST_CHECK;
                div_by_zero_d = 1'b0;
            end
            ST_CHECK: begin
                if (divisor_zero) begin
                    state_d       = ST_DONE;
                    div_by_zero_d = 1'b1;
                end else begin
                    state_d = ST_ITER;
                end
            end
            ST_ITER: begin
                if (cnt_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign load_divisor  = (state_q == ST_LOAD);
    assign load_dividend = (state_q == ST_LOAD);
    assign step          = (state_q == ST_ITER);
    assign write_rem     = (state_q == ST_ITER) & ~sub_negative;
    assign busy          = (state_q == ST_LOAD) | (state_q == ST_CHECK) | (state_q == ST_ITER);
    assign done          = (state_q == ST_DONE);
    assign div_by_zero   = div_by_zero_q;

endmodule

// File: tb/tb_divider_control.sv
// Randomized scoreboard bench for divider_control: a timeline model predicts
// every cycle's outputs, and a negedge monitor compares them against the DUT.
module tb_divider_control;

    localparam int W  = 8;
    localparam int CW = $clog2(W);

    typedef struct {
        int         cyc;
        logic [9:0] exp;
    } sb_entry_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic          divisor_zero;
    logic          sub_negative;
    logic          load_divisor;
    logic          load_dividend;
    logic          step;
    logic          write_rem;
    logic          busy;
    logic          done;
    logic          div_by_zero;
    logic [CW-1:0] iter_count;

    sb_entry_t sb[$];
    int        checks = 0;
    int        passes = 0;
    int        cyc    = 0;

    // Operation timeline model: offset k counts cycles since start was accepted.
    bit m_active = 0;
    int m_k      = 0;
    bit m_zero   = 0;
    bit m_dbz    = 0;

    divider_control #(.WIDTH(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .divisor_zero  (divisor_zero),
        .sub_negative  (sub_negative),
        .load_divisor  (load_divisor),
        .load_dividend (load_dividend),
        .step          (step),
        .write_rem     (write_rem),
        .busy          (busy),
        .done          (done),
        .div_by_zero   (div_by_zero),
        .iter_count    (iter_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] model_outputs(input logic sn);
        logic ld;
        logic st;
        logic bz;
        logic dn;
        int   it;
        ld = 1'b0; st = 1'b0; bz = 1'b0; dn = 1'b0; it = 0;
        if (m_active) begin
            ld = (m_k == 1);
            if (m_k == 1 || m_k == 2) bz = 1'b1;
            if (!m_zero && m_k >= 3 && m_k <= W + 2) begin
                st = 1'b1;
                bz = 1'b1;
                it = m_k - 3;
            end
            dn = m_zero ? (m_k == 3) : (m_k == W + 3);
        end
        return {ld, ld, st, st & ~sn, bz, dn, m_dbz, CW'(it)};
    endfunction

    task automatic model_update(input logic rst, input logic st, input logic dz);
        if (rst) begin
            m_active = 0;
            m_dbz    = 0;
        end else if (m_active) begin
            if (m_k == 1) m_dbz = 0;
            if (m_k == 2) begin
                m_zero = dz;
                if (dz) m_dbz = 1;
            end
            if ((m_zero && m_k == 3) || m_k == W + 3) m_active = 0;
            else m_k++;
        end else if (st) begin
            m_active = 1;
            m_k      = 1;
            m_zero   = 0;
        end
    endtask

    task automatic applyStimulus(input logic st, input logic rst, input logic dz, input logic sn);
        sb_entry_t e;
        start        = st;
        reset        = rst;
        divisor_zero = dz;
        sub_negative = sn;
        e.cyc = cyc;
        e.exp = model_outputs(sn);
        sb.push_back(e);
        @(posedge clk);
        model_update(rst, st, dz);
        cyc++;
        #1;
    endtask

    task automatic idle_cycles(input int n, input logic dz);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, dz, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic checkOutput(input sb_entry_t e, input logic [9:0] act);
        checks++;
        if (act === e.exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL outputs cycle %0d: got ld=%b%b step=%b wr=%b busy=%b done=%b dbz=%b it=%0d, expected ld=%b%b step=%b wr=%b busy=%b done=%b dbz=%b it=%0d",
                     e.cyc, act[9], act[8], act[7], act[6], act[5], act[4], act[3], act[2:0],
                     e.exp[9], e.exp[8], e.exp[7], e.exp[6], e.exp[5], e.exp[4], e.exp[3], e.exp[2:0]);
        end
    endtask

    initial begin : monitor
        sb_entry_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput(e, {load_divisor, load_dividend, step, write_rem, busy, done,
                                div_by_zero, iter_count});
            end
        end
    end

    initial begin : stimulus
        start        = 1'b0;
        reset        = 1'b1;
        divisor_zero = 1'b0;
        sub_negative = 1'b0;
        @(posedge clk);
        model_update(1'b1, 1'b0, 1'b0);
        #1;

        // Reset then quiet idle.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        idle_cycles(5, 1'b0);

        // Normal division with alternating trial-subtraction sign.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < W; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'(i % 2));
        end
        idle_cycles(3, 1'b0);

        // Divide by zero; flag must persist until the next LOAD.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        idle_cycles(6, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(W + 5, 1'b0);

        // Start held high for 30 cycles.
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
        end
        idle_cycles(W + 4, 1'b0);

        // Reset during the fourth ITER cycle.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(5, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        idle_cycles(W + 4, 1'b0);

        // Reset and start together in IDLE.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        idle_cycles(4, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 2) == 0),
                          1'($urandom_range(0, 59) == 0),
                          1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 1)));
        end
        idle_cycles(W + 5, 1'b0);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            passes++;
        end else begin
            $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/divider_control.md
# divider_control

Sequencing FSM for the 8-bit restoring divider datapath. On a `start` request it loads the divisor register and the dividend/remainder shift register, checks for a zero divisor, then runs one shift-and-subtract step per quotient bit. It signals completion with a single-cycle `done` pulse. It sits between the top-level handshake and the datapath; it holds no operand data itself.

## Interface
- `WIDTH`, default 8: quotient bits, which is also the iteration count. Legal range is 2..16.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; returns the FSM to IDLE.
- `start`  in  1  request a division; sampled only in IDLE.
- `divisor_zero`  in  1  datapath flag: divisor register output == 0.
- `sub_negative`  in  1  datapath flag: sign of the trial subtraction (shifted remainder − divisor) in the current cycle.
- `load_divisor`  out  1  load enable to the divisor register.
- `load_dividend`  out  1  load enable to the remainder/quotient register (remainder cleared, quotient ← dividend).
- `step`  out  1  shift the remainder/quotient pair left by one.
- `write_rem`  out  1  replace the remainder with the trial difference; also the new quotient LSB.
- `busy`  out  1  high in LOAD, CHECK and ITER.
- `done`  out  1  one-cycle completion pulse.
- `div_by_zero`  out  1  error flag for the last operation.
- `iter_count`  out  clog2(WIDTH)  current iteration index, for debug and observation.

## Operation
- States: IDLE, LOAD, CHECK, ITER, DONE. All outputs except `div_by_zero` are Moore, decoded from state; `write_rem` also depends on `sub_negative`.
- IDLE:
  - `start`=1 → LOAD.
  - Otherwise stay in IDLE; all strobes are 0.
- LOAD:
  - `load_divisor`=`load_dividend`=1 for exactly one cycle.
  - Clears `div_by_zero` and `iter_count`.
  - → CHECK.
- CHECK:
  - Samples `divisor_zero`, which now reflects the newly loaded divisor.
  - 1 → set `div_by_zero`, → DONE.
  - 0 → ITER.
- ITER:
  - `step`=1 every cycle; `write_rem` = ~`sub_negative`.
  - `iter_count` increments each cycle.
  - At `iter_count`==WIDTH−1 → DONE, and the counter wraps to 0.
- DONE:
  - `done`=1 for one cycle; `busy`=0.
  - → IDLE unconditionally.
- `start` is ignored in LOAD, CHECK, ITER and DONE. It is not queued.
- `div_by_zero` holds its value from DONE until the next LOAD or a reset.
- On divide-by-zero, the datapath quotient and remainder are undefined; `step` is never asserted.

## Timing
- Reset values: state IDLE, `iter_count`=0, and every output 0.
- `reset` asserted in any state (including mid-ITER) → IDLE on the next edge.
  - No further strobes are issued.
  - `done` is not pulsed.
  - `div_by_zero` is cleared.
- `reset` has priority over `start` in the same cycle.
- Latency with `start` sampled high in IDLE in cycle N:
  - LOAD at N+1, CHECK at N+2.
  - ITER at N+3 through N+WIDTH+2.
  - `done` at N+WIDTH+3 (N+11 for WIDTH=8).
- Divide-by-zero latency: `done` with `div_by_zero`=1 at N+3.
- Back-to-back: the earliest next `start` is sampled in the IDLE cycle after DONE. Throughput is one division per WIDTH+4 cycles.
- Exactly WIDTH `step` pulses occur per non-zero-divisor operation, and they are contiguous.
- `sub_negative` must be valid combinationally within each ITER cycle. `write_rem` is registered by the datapath on the same edge as `step`.

## Structure
- Shared package `divider_pkg` holds:
  - the state encoding constants: IDLE=0, LOAD=1, CHECK=2, ITER=3, DONE=4 (3 bits);
  - `WIDTH` default 8;
  - the counter width localparam.
- Sub-module `div_iter_counter` is a clog2(WIDTH)-bit counter with synchronous reset.
  - Inputs: `clear`, `enable`.
  - Output: `last` (count == WIDTH−1).
  - The FSM instantiates it; the next-state logic consumes `last`.
- The FSM itself is a single state register plus combinational next-state and output decode.

## Test plan
- Reset, then idle 5 cycles with `start`=0 → all outputs 0, state IDLE, `iter_count`=0.
- Start with `divisor_zero`=0 and `sub_negative` alternating 0/1 per ITER cycle:
  - `load_*` high only at N+1;
  - 8 `step` pulses at N+3..N+10, with `write_rem` pattern 1,0,1,0,1,0,1,0;
  - `done` only at N+11; `busy` high N+1..N+10.
- Start with `divisor_zero`=1 in CHECK → no `step`; `done` and `div_by_zero`=1 at N+3; `div_by_zero` stays 1 until the next LOAD.
- `start` held high continuously for 30 cycles → operations begin at N, N+12 and N+24; `start` pulses during busy are ignored.
- `reset` asserted at ITER cycle 4 → IDLE next cycle; no `done`; `step` stays 0 and `iter_count`=0 thereafter.
- Reset and `start` asserted together in IDLE → remains IDLE; no `load_*` pulse.
